// File: rtl/sprite_pkg.sv
// sprite_pkg: shared palette, attribute record and defaults for the sprite compositor
package sprite_pkg;
  localparam int TRANSP_IDX_DEF = 5;
  localparam int TRIG_MAX_W = 16;
  localparam logic [23:0] PALETTE [8] = '{
    24'hFF3131, 24'h312D2B, 24'h878685, 24'h9B9DA0,
    24'hFFE100, 24'hFF00D6, 24'h000000, 24'hFFFFFF
  };
  typedef struct packed {
    logic [9:0]                   x;
    logic [9:0]                   y;
    logic signed [TRIG_MAX_W-1:0] sin;
    logic signed [TRIG_MAX_W-1:0] cos;
    logic                         vis;
  } sprite_attr_t;
endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: video timing, attribute write, ROM and colour signals of the compositor
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = 9,
  parameter int TRIG_W      = 8
);
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
  logic [9:0]                    DrawX;
  logic [9:0]                    DrawY;
  logic                          blank;
  logic                          frame_start;
  logic                          wr_en;
  logic [IW-1:0]                 wr_idx;
  logic [9:0]                    wr_x;
  logic [9:0]                    wr_y;
  logic [TRIG_W-1:0]             wr_sin;
  logic [TRIG_W-1:0]             wr_cos;
  logic                          wr_vis;
  logic [23:0]                   bg_rgb;
  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr;
  logic [NUM_SPRITES*3-1:0]      rom_data;
  logic [7:0]                    Red;
  logic [7:0]                    Green;
  logic [7:0]                    Blue;
  logic                          out_blank;
  modport master (
    output DrawX, DrawY, blank, frame_start, wr_en, wr_idx, wr_x, wr_y,
           wr_sin, wr_cos, wr_vis, bg_rgb, rom_data,
    input  rom_addr, Red, Green, Blue, out_blank
  );
  modport slave (
    input  DrawX, DrawY, blank, frame_start, wr_en, wr_idx, wr_x, wr_y,
           wr_sin, wr_cos, wr_vis, bg_rgb, rom_data,
    output rom_addr, Red, Green, Blue, out_blank
  );
endinterface

// File: rtl/sprite_rotator.sv
// sprite_rotator: rotates the pixel into one sprite's texel space, bounds-checks it and registers the ROM address
module sprite_rotator
  import sprite_pkg::*;
#(
  parameter int SPR_DIM = 20,
  parameter int ADDR_W  = 9,
  parameter int TRIG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  sprite_attr_t      attr_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] addr_o
);
  localparam int H = SPR_DIM / 2;
  logic signed [31:0] dx, dy, c, s, sx, sy;
  logic hit_d, hit_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  // Offsets are widened before subtracting so off-screen sprites never wrap around
  always_comb begin
    dx = 32'(draw_x_i) - 32'(attr_i.x);
    dy = 32'(draw_y_i) - 32'(attr_i.y);
    c = 32'($signed(attr_i.cos));
    s = 32'($signed(attr_i.sin));
    sx = (dx * c + dy * s) >>> (TRIG_W - 2);
    sy = (dy * c - dx * s) >>> (TRIG_W - 2);
    hit_d = attr_i.vis && sx >= -H && sx < H && sy >= -H && sy < H;
    addr_d = hit_d ? ADDR_W'((sy + H) * SPR_DIM + sx + H) : '0;
  end
  // Stage-1 registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_q <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q <= hit_d;
      addr_q <= addr_d;
    end
  assign hit_o = hit_q;
  assign addr_o = addr_q;
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: three-stage compositor of rotated palette sprites over a background colour
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_DIM     = 20,
  parameter int ADDR_W      = 9,
  parameter int TRIG_W      = 8,
  parameter int TRANSP_IDX  = TRANSP_IDX_DEF
) (
  input logic               CLK,
  input logic               Reset_n,
  sprite_compositor_if.slave bus
);
  sprite_attr_t pend_q [NUM_SPRITES];
  sprite_attr_t act_q [NUM_SPRITES];
  sprite_attr_t wr_attr;
  logic [NUM_SPRITES-1:0] hit1, hit2_q;
  logic [NUM_SPRITES*ADDR_W-1:0] addr1;
  logic blank1_q, blank2_q, oblank_q;
  logic [23:0] rgb_d, rgb_q;
  assign wr_attr = '{bus.wr_x, bus.wr_y, TRIG_MAX_W'($signed(bus.wr_sin)),
                     TRIG_MAX_W'($signed(bus.wr_cos)), bus.wr_vis};
  // Pending bank takes writes; the active bank copies the pre-write pending bank on frame_start
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      pend_q <= '{default: '0};
      act_q <= '{default: '0};
    end else begin
      if (bus.frame_start) act_q <= pend_q;
      if (bus.wr_en && 32'(bus.wr_idx) < NUM_SPRITES) pend_q[bus.wr_idx] <= wr_attr;
    end
  genvar i;
  for (i = 0; i < NUM_SPRITES; i++) begin : g_rot
    sprite_rotator #(.SPR_DIM(SPR_DIM), .ADDR_W(ADDR_W), .TRIG_W(TRIG_W)) u_rot (
      .clk(CLK),
      .rst_n(Reset_n),
      .draw_x_i(bus.DrawX),
      .draw_y_i(bus.DrawY),
      .attr_i(act_q[i]),
      .hit_o(hit1[i]),
      .addr_o(addr1[i*ADDR_W +: ADDR_W])
    );
  end
  // Highest channel first so the lowest qualifying channel overwrites last and wins
  always_comb begin
    rgb_d = bus.bg_rgb;
    for (int k = NUM_SPRITES - 1; k >= 0; k--)
      if (hit2_q[k] && 32'(bus.rom_data[k*3 +: 3]) != TRANSP_IDX) rgb_d = PALETTE[bus.rom_data[k*3 +: 3]];
    if (!blank2_q) rgb_d = '0;
  end
  // Delay blank and hits to meet rom_data, then register the final colour
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      blank1_q <= 1'b0;
      blank2_q <= 1'b0;
      hit2_q <= '0;
      rgb_q <= '0;
      oblank_q <= 1'b0;
    end else begin
      blank1_q <= bus.blank;
      blank2_q <= blank1_q;
      hit2_q <= hit1;
      rgb_q <= rgb_d;
      oblank_q <= blank2_q;
    end
  assign bus.rom_addr = addr1;
  assign bus.Red = rgb_q[23:16];
  assign bus.Green = rgb_q[15:8];
  assign bus.Blue = rgb_q[7:0];
  assign bus.out_blank = oblank_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized check of the compositor against a per-pixel reference model
module tb_sprite_compositor;
  localparam int NS = 4;
  localparam int AW = 9;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  sprite_compositor_if #(.NUM_SPRITES(NS), .ADDR_W(AW), .TRIG_W(8)) bus ();
  sprite_compositor #(.NUM_SPRITES(NS), .SPR_DIM(20), .ADDR_W(AW), .TRIG_W(8), .TRANSP_IDX(5)) dut (
    .CLK(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );
  logic [2:0] rom_mem [NS][512];
  always @(posedge clk)
    for (int c = 0; c < NS; c++) bus.rom_data[c*3 +: 3] <= rom_mem[c][bus.rom_addr[c*AW +: AW]];
  localparam logic [23:0] PAL [8] = '{
    24'hFF3131, 24'h312D2B, 24'h878685, 24'h9B9DA0,
    24'hFFE100, 24'hFF00D6, 24'h000000, 24'hFFFFFF
  };
  typedef struct { int x, y, s, c; bit v; } mattr_t;
  mattr_t pend [NS];
  mattr_t act [NS];
  logic [24:0] exp_q [$];
  logic [NS*AW-1:0] addr_prev;
  int total = 0;
  int bad = 0;
  logic [9:0] s_x, s_y;
  bit s_blank, s_fs, s_wen, s_rst, s_wv;
  int s_widx, s_wx, s_wy, s_ws, s_wc;
  logic [23:0] bg = 24'h2468AC;
  int ts [8] = '{0, 64, 45, -45, 0, -64, 32, 0};
  int tc [8] = '{64, 0, 45, 45, -64, 0, 55, 0};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int fdiv64(input int a);
    int q;
    q = a / 64;
    if (a < 0 && q * 64 != a) q--;
    return q;
  endfunction
  function automatic logic [24:0] model(output logic [NS*AW-1:0] av);
    logic [23:0] rgb;
    bit found, hit;
    int dx, dy, sx, sy, a;
    rgb = bg;
    found = 0;
    av = '0;
    for (int c = 0; c < NS; c++) begin
      dx = int'(s_x) - act[c].x;
      dy = int'(s_y) - act[c].y;
      sx = fdiv64(dx * act[c].c + dy * act[c].s);
      sy = fdiv64(dy * act[c].c - dx * act[c].s);
      hit = act[c].v && sx >= -10 && sx < 10 && sy >= -10 && sy < 10;
      a = hit ? (sy + 10) * 20 + sx + 10 : 0;
      av[c*AW +: AW] = AW'(a);
      if (hit && !found && rom_mem[c][a] != 3'd5) begin
        found = 1;
        rgb = PAL[rom_mem[c][a]];
      end
    end
    return s_blank ? {1'b1, rgb} : 25'd0;
  endfunction
  task automatic step(input bit fe = 0, input logic [24:0] fv = '0);
    logic [24:0] e, m;
    logic [NS*AW-1:0] av;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("rgb", {bus.Red, bus.Green, bus.Blue}, e[23:0]);
    chk("out_blank", bus.out_blank, e[24]);
    chk("rom_addr", bus.rom_addr, addr_prev);
    bus.DrawX = s_x;
    bus.DrawY = s_y;
    bus.blank = s_blank;
    bus.frame_start = s_fs;
    bus.wr_en = s_wen;
    bus.wr_idx = 2'(s_widx);
    bus.wr_x = 10'(s_wx);
    bus.wr_y = 10'(s_wy);
    bus.wr_sin = 8'(s_ws);
    bus.wr_cos = 8'(s_wc);
    bus.wr_vis = s_wv;
    if (!s_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_rgb", {bus.Red, bus.Green, bus.Blue}, 0);
      chk("rst_blank", bus.out_blank, 0);
      chk("rst_addr", bus.rom_addr, 0);
      foreach (exp_q[i]) exp_q[i] = '0;
      exp_q.push_back('0);
      addr_prev = '0;
      foreach (act[i]) begin
        act[i] = '{0, 0, 0, 0, 0};
        pend[i] = '{0, 0, 0, 0, 0};
      end
    end else begin
      rst_n = 1'b1;
      m = model(av);
      exp_q.push_back(fe ? fv : m);
      addr_prev = av;
      if (s_fs) act = pend;
      if (s_wen) pend[s_widx] = '{s_wx, s_wy, s_ws, s_wc, s_wv};
    end
    s_wen = 0;
    s_fs = 0;
  endtask
  task automatic px(input int x, input int y, input bit b, input logic [23:0] rgb);
    s_x = 10'(x);
    s_y = 10'(y);
    s_blank = b;
    step(1, b ? {1'b1, rgb} : 25'd0);
  endtask
  task automatic wr(input int idx, input int x, input int y, input int sn, input int cs, input bit v, input bit fs);
    s_wen = 1;
    s_widx = idx;
    s_wx = x;
    s_wy = y;
    s_ws = sn;
    s_wc = cs;
    s_wv = v;
    s_fs = fs;
    s_blank = 0;
    step();
  endtask
  task automatic fsync();
    s_fs = 1;
    s_blank = 0;
    step();
  endtask
  task automatic idle(input int n);
    s_blank = 0;
    repeat (n) step();
  endtask
  initial begin
    int k;
    foreach (rom_mem[c, a]) rom_mem[c][a] = 3'd0;
    bus.bg_rgb = bg;
    s_x = 0; s_y = 0; s_blank = 0; s_fs = 0; s_wen = 0; s_rst = 0;
    s_widx = 0; s_wx = 0; s_wy = 0; s_ws = 0; s_wc = 0; s_wv = 0;
    foreach (act[i]) begin
      act[i] = '{0, 0, 0, 0, 0};
      pend[i] = '{0, 0, 0, 0, 0};
    end
    repeat (3) exp_q.push_back('0);
    addr_prev = '0;
    #1 rst_n = 1'b0;
    repeat (2) step();
    s_rst = 1;
    wr(0, 100, 100, 0, 64, 1, 0);
    fsync();
    px(90, 90, 1, 24'hFF3131);
    @(posedge clk); #1 chk("addr_corner", bus.rom_addr[8:0], 0);
    px(110, 100, 1, bg);
    wr(0, 100, 100, 64, 0, 1, 0);
    fsync();
    px(100, 95, 1, 24'hFF3131);
    @(posedge clk); #1 chk("addr_rot90", bus.rom_addr[8:0], 205);
    wr(0, 100, 100, 0, 64, 1, 0);
    wr(1, 100, 100, 0, 64, 1, 0);
    fsync();
    idle(3);
    rom_mem[0][0] = 3'd5;
    rom_mem[1][0] = 3'd4;
    px(90, 90, 1, 24'hFFE100);
    idle(3);
    rom_mem[0][0] = 3'd7;
    px(90, 90, 1, 24'hFFFFFF);
    idle(3);
    rom_mem[2][210] = 3'd3;
    wr(2, 300, 200, 0, 64, 1, 0);
    px(300, 200, 1, bg);
    fsync();
    px(300, 200, 1, 24'h9B9DA0);
    wr(2, 500, 200, 0, 64, 1, 1);
    px(300, 200, 1, 24'h9B9DA0);
    px(500, 200, 1, bg);
    fsync();
    px(300, 200, 1, bg);
    px(500, 200, 1, 24'h9B9DA0);
    px(90, 90, 0, 24'h0);
    s_x = 90; s_y = 90; s_blank = 1;
    repeat (2) step();
    s_rst = 0;
    repeat (2) step();
    s_rst = 1;
    repeat (5) step();
    idle(3);
    foreach (rom_mem[c, a]) rom_mem[c][a] = 3'($urandom_range(0, 7));
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) begin
        s_wen = 1;
        s_widx = $urandom_range(0, NS - 1);
        s_wx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : $urandom_range(50, 150);
        s_wy = $urandom_range(50, 150);
        k = $urandom_range(0, 7);
        s_ws = (k == 7) ? int'($urandom_range(0, 128)) - 64 : ts[k];
        s_wc = (k == 7) ? int'($urandom_range(0, 128)) - 64 : tc[k];
        s_wv = $urandom_range(0, 4) != 0;
      end
      s_fs = $urandom_range(0, 15) == 0;
      s_x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(30, 170));
      s_y = 10'($urandom_range(30, 170));
      s_blank = $urandom_range(0, 9) != 0;
      step();
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the per-pixel colour mapper.
- Composites NUM_SPRITES rotated, palette-indexed sprites (tanks, bullets) over a background colour.
- Uses a fixed 3-cycle pipeline with double-buffered sprite attributes, so game logic can update positions and angles at any time without tearing.
- Sits between the VGA controller (DrawX/DrawY/blank) and the DAC/HDMI encoder; sprite ROMs are external synchronous ROMs.

Parameters:
- NUM_SPRITES, 4, number of sprite channels; index 0 has highest priority.
- SPR_DIM, 20, sprite edge length in pixels; must be even.
- ADDR_W, 9, ROM address width; must satisfy 2^ADDR_W >= SPR_DIM*SPR_DIM.
- TRIG_W, 8, signed sin/cos width, fixed point Q1.(TRIG_W-2), so 64 = 1.0.
- TRANSP_IDX, 5, palette index treated as transparent.

Ports:
- CLK  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- wr_en  in  1  attribute write strobe.
- wr_idx  in  $clog2(NUM_SPRITES)  channel being written.
- wr_x  in  10  sprite centre X.
- wr_y  in  10  sprite centre Y.
- wr_sin  in  TRIG_W  signed sine of the sprite angle.
- wr_cos  in  TRIG_W  signed cosine of the sprite angle.
- wr_vis  in  1  sprite enable.
- bg_rgb  in  24  background colour.
- rom_addr  out  NUM_SPRITES*ADDR_W  per-channel ROM address; channel i occupies slice [i*ADDR_W +: ADDR_W].
- rom_data  in  NUM_SPRITES*3  per-channel palette index; valid one cycle after rom_addr is sampled.
- Red  out  8  colour out.
- Green  out  8  colour out.
- Blue  out  8  colour out.
- out_blank  out  1  blank delayed to align with Red/Green/Blue.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - Pending and active attribute banks cleared (x=y=sin=cos=0, vis=0).
  - All pipeline registers cleared; rom_addr=0; Red/Green/Blue=0; out_blank=0.
- Attribute write: on a CLK edge with wr_en=1, the pending bank entry wr_idx takes {wr_x, wr_y, wr_sin, wr_cos, wr_vis}. An out-of-range wr_idx is ignored.
- Bank swap: on a CLK edge with frame_start=1, the active bank takes the entire pending bank.
  - If wr_en and frame_start occur in the same cycle, the copy uses the pre-write pending contents; the new write becomes visible at the next frame_start.
  - Pending data is otherwise unaffected by the swap.
- Pipeline: fixed latency of 3. Inputs sampled at edge t produce Red/Green/Blue/out_blank at edge t+3. There is no stall and no backpressure.
- Stage 1 (edge t+1), per channel, using active-bank attributes:
  - dx = DrawX - x and dy = DrawY - y, both signed 11-bit.
  - sx = (dx*cos + dy*sin) >>> (TRIG_W-2)
  - sy = (dy*cos - dx*sin) >>> (TRIG_W-2)
  - Arithmetic shift, full-precision products, floor rounding.
  - hit_i = vis & (-SPR_DIM/2 <= sx < SPR_DIM/2) & (same condition on sy).
  - rom_addr_i = (sy+SPR_DIM/2)*SPR_DIM + (sx+SPR_DIM/2), registered. rom_addr_i is 0 when hit_i=0.
  - blank and hit_i are registered alongside.
- Stage 2 (edge t+2):
  - hit and blank are delayed one more cycle to align with rom_data.
- Stage 3 (edge t+3):
  - If the delayed blank=0: RGB=0.
  - Otherwise: the lowest channel i with hit_i=1 and rom_data_i != TRANSP_IDX selects PALETTE[rom_data_i].
  - If no channel qualifies: RGB=bg_rgb.
  - out_blank follows the delayed blank.
- Boundary conditions:
  - Sprite partially off-screen: dx/dy wrap is prevented by the 11-bit signed math, so no ghost image appears at the opposite edge.
  - sin=cos=0: sx=sy=0, so the whole screen maps to the sprite centre texel. This is legal; software must not do it.
  - Reset deasserted mid-frame: output stays black until 3 valid edges have passed.

Decomposition:
- Package sprite_pkg:
  - PALETTE[8] 24-bit constants: FF3131, 312D2B, 878685, 9B9DA0, FFE100, FF00D6, 000000, FFFFFF.
  - sprite_attr_t packed struct {x, y, sin, cos, vis}.
  - Default TRANSP_IDX.
- Sub-module sprite_rotator: stage-1 transform, bounds check and address generation for one channel, with registered outputs. Instanced NUM_SPRITES times via generate.

Test Plan:
- Reset mid-stream with blank=1 and sprites visible -> RGB=0 and out_blank=0 immediately; first non-zero RGB appears exactly 3 edges after Reset_n rises.
- One sprite at (100,100), cos=64, sin=0, ROM returning index 0:
  - DrawX=90, DrawY=90 -> rom_addr=0, RGB=FF3131 at t+3.
  - DrawX=110, DrawY=100 -> outside the sprite, RGB=bg_rgb.
- Same sprite with cos=0, sin=64 (90 degrees), DrawX=100, DrawY=95 -> sx=-5, sy=0, rom_addr=205.
- Channels 0 and 1 overlap at one pixel:
  - ch0 data=TRANSP_IDX, ch1 data=4 -> RGB=FFE100.
  - ch0 data=7 -> RGB=FFFFFF.
- Write ch2 x=300 with frame_start low -> no change on screen. frame_start pulse -> new position used from the next pixel. Write coinciding with frame_start -> old value held one extra frame.
- blank=0 with a sprite hit -> RGB=000000 and out_blank=0, aligned at t+3.
